// File: rtl/gps_ack_peak_if.sv
// gps_ack_peak_if
//   Report stream from gps_ack_peak to the channel-allocation logic. There is one
//   record per correlator lane. A record transfers on any clock edge where
//   res_valid & res_ready.
//   master (peak tracker) : drives res_valid and the record fields, samples res_ready
//   slave  (consumer)     : samples res_valid and the record fields, drives res_ready
interface gps_ack_peak_if;
  logic               res_valid;
  logic               res_ready;
  logic [2:0]         res_lane;
  logic [5:0]         res_sat;
  logic [11:0]        res_peak;
  logic [9:0]         res_code_phase;
  logic signed [15:0] res_doppler;
  logic               res_detected;

  modport master (
    output res_valid, res_lane, res_sat, res_peak, res_code_phase, res_doppler, res_detected,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_lane, res_sat, res_peak, res_code_phase, res_doppler, res_detected,
    output res_ready
  );
endinterface

// File: rtl/gps_ack_peak.sv
// gps_ack_peak
//   This block sits after gps_ack. Each rising edge of corr_complete carries a new set of
//   8-lane correlation results. For each lane, the block keeps the largest integrator
//   value seen during the search, together with the PRN, code phase and doppler that
//   came with it. A rising edge of search_complete starts the report. The report sends
//   one record per lane, in lane order, over the res stream. Each record flags whether
//   its peak reaches THRESH.
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   ack_start                 1-cycle pulse; clears all lane state and (re)enters ACCUM
//   corr_complete             result-set strobe (rising edge is used)
//   search_complete           end-of-search strobe (rising edge is used)
//   sat0..7, integrator_0..7  per-lane PRN and unsigned correlation magnitude
//   code_phase, doppler_omega code phase and signed doppler shared by the result set
//   res (master)              report stream: valid/ready plus the lane record
//   corr_count                result sets absorbed during this search (saturating)
//   busy                      high in ACCUM and REPORT
//   report_done               1-cycle pulse on the cycle after lane 7 is accepted
//
// state  | meaning
// IDLE   | waiting for ack_start; result and search strobes are ignored
// ACCUM  | absorbing result sets into the per-lane peaks
// REPORT | presenting one record per lane; returns to IDLE after the last lane is accepted
module gps_ack_peak #(
  parameter int          LANES  = 8,       // fixed by the gps_ack lane count
  parameter logic [11:0] THRESH = 12'd600,
  parameter int          CNT_W  = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ack_start,
  input  logic               corr_complete,
  input  logic               search_complete,
  input  logic [5:0]         sat0, sat1, sat2, sat3, sat4, sat5, sat6, sat7,
  input  logic [11:0]        integrator_0, integrator_1, integrator_2, integrator_3,
  input  logic [11:0]        integrator_4, integrator_5, integrator_6, integrator_7,
  input  logic [9:0]         code_phase,
  input  logic signed [15:0] doppler_omega,
  gps_ack_peak_if.master     res,
  output logic [CNT_W-1:0]   corr_count,
  output logic               busy,
  output logic               report_done
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCUM  = 2'd1;
  localparam logic [1:0] REPORT = 2'd2;

  logic [1:0]         state;
  logic               corr_prev, search_prev;
  logic               corr_ev, search_ev, absorb;

  logic [5:0]         sat_in   [LANES];
  logic [11:0]        integ_in [LANES];

  logic [11:0]        peak_q [LANES];
  logic [9:0]         cp_q   [LANES];
  logic signed [15:0] dop_q  [LANES];
  logic [5:0]         sat_q  [LANES];

  logic [11:0]        peak_nxt [LANES];
  logic [9:0]         cp_nxt   [LANES];
  logic signed [15:0] dop_nxt  [LANES];
  logic [5:0]         sat_nxt  [LANES];

  logic [2:0]         rec_idx;
  logic [11:0]        rec_peak;
  logic [9:0]         rec_cp;
  logic signed [15:0] rec_dop;
  logic [5:0]         rec_sat;

  assign sat_in[0] = sat0;  assign integ_in[0] = integrator_0;
  assign sat_in[1] = sat1;  assign integ_in[1] = integrator_1;
  assign sat_in[2] = sat2;  assign integ_in[2] = integrator_2;
  assign sat_in[3] = sat3;  assign integ_in[3] = integrator_3;
  assign sat_in[4] = sat4;  assign integ_in[4] = integrator_4;
  assign sat_in[5] = sat5;  assign integ_in[5] = integrator_5;
  assign sat_in[6] = sat6;  assign integ_in[6] = integrator_6;
  assign sat_in[7] = sat7;  assign integ_in[7] = integrator_7;

  assign corr_ev   = corr_complete & ~corr_prev;
  assign search_ev = search_complete & ~search_prev;
  assign absorb    = (state == ACCUM) & corr_ev & ~ack_start;
  assign busy      = (state != IDLE);

  // The strict compare means a tie keeps the earlier result.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      peak_nxt[i] = peak_q[i];
      cp_nxt[i]   = cp_q[i];
      dop_nxt[i]  = dop_q[i];
      sat_nxt[i]  = sat_q[i];
      if (absorb && (integ_in[i] > peak_q[i])) begin
        peak_nxt[i] = integ_in[i];
        cp_nxt[i]   = code_phase;
        dop_nxt[i]  = doppler_omega;
        sat_nxt[i]  = sat_in[i];
      end
    end
  end

  // Choose which record to load next. On entry to REPORT this is lane 0. It is read
  // through the *_nxt path so that a result set arriving on the same edge as the search
  // edge is already included. During REPORT the *_nxt values equal the registers.
  always_comb begin
    rec_idx  = (state == ACCUM) ? 3'd0 : (res.res_lane + 3'd1);
    rec_peak = peak_nxt[rec_idx];
    rec_cp   = cp_nxt[rec_idx];
    rec_dop  = dop_nxt[rec_idx];
    rec_sat  = sat_nxt[rec_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= IDLE;
      corr_prev          <= 1'b0;
      search_prev        <= 1'b0;
      corr_count         <= '0;
      report_done        <= 1'b0;
      res.res_valid      <= 1'b0;
      res.res_lane       <= '0;
      res.res_sat        <= '0;
      res.res_peak       <= '0;
      res.res_code_phase <= '0;
      res.res_doppler    <= '0;
      res.res_detected   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        peak_q[i] <= '0;
        cp_q[i]   <= '0;
        dop_q[i]  <= '0;
        sat_q[i]  <= '0;
      end
    end else begin
      corr_prev   <= corr_complete;
      search_prev <= search_complete;
      report_done <= 1'b0;
      if (ack_start) begin
        // Abort or restart from any state. The record fields keep their old values.
        state         <= ACCUM;
        corr_count    <= '0;
        res.res_valid <= 1'b0;
        for (int i = 0; i < LANES; i++) begin
          peak_q[i] <= '0;
          cp_q[i]   <= '0;
          dop_q[i]  <= '0;
          sat_q[i]  <= '0;
        end
      end else begin
        case (state)
          IDLE: begin
          end
          ACCUM: begin
            for (int i = 0; i < LANES; i++) begin
              peak_q[i] <= peak_nxt[i];
              cp_q[i]   <= cp_nxt[i];
              dop_q[i]  <= dop_nxt[i];
              sat_q[i]  <= sat_nxt[i];
            end
            if (corr_ev && (corr_count != '1))
              corr_count <= corr_count + 1'b1;
            if (search_ev) begin
              state              <= REPORT;
              res.res_valid      <= 1'b1;
              res.res_lane       <= rec_idx;
              res.res_peak       <= rec_peak;
              res.res_code_phase <= rec_cp;
              res.res_doppler    <= rec_dop;
              res.res_sat        <= rec_sat;
              res.res_detected   <= (rec_peak >= THRESH);
            end
          end
          REPORT: begin
            if (res.res_ready) begin
              if (res.res_lane == 3'(LANES - 1)) begin
                state         <= IDLE;
                res.res_valid <= 1'b0;
                report_done   <= 1'b1;
              end else begin
                res.res_lane       <= rec_idx;
                res.res_peak       <= rec_peak;
                res.res_code_phase <= rec_cp;
                res.res_doppler    <= rec_dop;
                res.res_sat        <= rec_sat;
                res.res_detected   <= (rec_peak >= THRESH);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gps_ack_peak.sv
module tb_gps_ack_peak;

  typedef struct packed {
    logic [7:0][11:0]   integ;
    logic [9:0]         cp;
    logic signed [15:0] dop;
    logic [5:0]         sat_base;   // PRN of lane n is sat_base + n
  } set_t;

  typedef struct packed {
    logic [11:0]        peak;
    logic [9:0]         cp;
    logic signed [15:0] dop;
    logic [5:0]         sat;
    logic               det;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic               ack_start = 1'b0, corr_complete = 1'b0, search_complete = 1'b0;
  logic [5:0]         sat [8];
  logic [11:0]        integ [8];
  logic [9:0]         code_phase = '0;
  logic signed [15:0] doppler_omega = '0;
  logic [19:0]        corr_count;
  logic               busy, report_done;

  gps_ack_peak_if res_if();

  gps_ack_peak dut (
    .clk(clk), .rst(rst), .ack_start(ack_start),
    .corr_complete(corr_complete), .search_complete(search_complete),
    .sat0(sat[0]), .sat1(sat[1]), .sat2(sat[2]), .sat3(sat[3]),
    .sat4(sat[4]), .sat5(sat[5]), .sat6(sat[6]), .sat7(sat[7]),
    .integrator_0(integ[0]), .integrator_1(integ[1]), .integrator_2(integ[2]),
    .integrator_3(integ[3]), .integrator_4(integ[4]), .integrator_5(integ[5]),
    .integrator_6(integ[6]), .integrator_7(integ[7]),
    .code_phase(code_phase), .doppler_omega(doppler_omega),
    .res(res_if), .corr_count(corr_count), .busy(busy), .report_done(report_done)
  );

  set_t       sets [6];
  rec_t       exp_tbl [32];
  logic [19:0] exp_cnt [4];
  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  always @(negedge clk) if (report_done) done_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
    end
  endtask

  task automatic apply_set(input int k, input bit with_search);
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      integ[n] = sets[k].integ[n];
      sat[n]   = sets[k].sat_base + 6'(n);
    end
    code_phase      = sets[k].cp;
    doppler_omega   = sets[k].dop;
    corr_complete   = 1'b1;
    search_complete = with_search;
    @(negedge clk);
    corr_complete   = 1'b0;
    search_complete = 1'b0;
  endtask

  task automatic start_search();
    @(negedge clk);
    ack_start = 1'b1;
    @(negedge clk);
    ack_start = 1'b0;
  endtask

  task automatic search_edge();
    @(negedge clk);
    search_complete = 1'b1;
    @(negedge clk);
    search_complete = 1'b0;
  endtask

  // Takes nrec records of search s and stalls the consumer for 5 cycles on stall_lane.
  // Each loop pass is one cycle after the previous handshake, so valid must already be
  // high again (no bubble between records).
  task automatic collect(input int s, input int nrec, input int stall_lane);
    int w;
    int d0;
    rec_t e;
    d0 = done_cnt;
    res_if.res_ready = 1'b1;
    w = 0;
    while (!res_if.res_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!res_if.res_valid) begin
      check("valid_timeout", 32'(res_if.res_valid), 32'd1);
      return;
    end
    check("corr_count", 32'(corr_count), 32'(exp_cnt[s]));
    for (int i = 0; i < nrec; i++) begin
      e = exp_tbl[s*8 + i];
      check("rec_valid",  32'(res_if.res_valid), 32'd1);
      check("rec_lane",   32'(res_if.res_lane), 32'(i));
      check("rec_peak",   32'(res_if.res_peak), 32'(e.peak));
      check("rec_cp",     32'(res_if.res_code_phase), 32'(e.cp));
      check("rec_dop",    32'(res_if.res_doppler), 32'(e.dop));
      check("rec_sat",    32'(res_if.res_sat), 32'(e.sat));
      check("rec_det",    32'(res_if.res_detected), 32'(e.det));
      if (i == stall_lane) begin
        res_if.res_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          @(negedge clk);
          check("stall_valid", 32'(res_if.res_valid), 32'd1);
          check("stall_lane",  32'(res_if.res_lane), 32'(i));
          check("stall_peak",  32'(res_if.res_peak), 32'(e.peak));
          check("stall_cp",    32'(res_if.res_code_phase), 32'(e.cp));
        end
        res_if.res_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (nrec == 8) begin
      check("end_valid",   32'(res_if.res_valid), 32'd0);
      check("end_done",    32'(report_done), 32'd1);
      check("end_busy",    32'(busy), 32'd0);
      @(negedge clk);
      check("done_pulse",  32'(report_done), 32'd0);
      @(negedge clk);
      check("done_count",  32'(done_cnt - d0), 32'd1);
    end
  endtask

  initial begin
    int d;
    for (int i = 0; i < 6; i++) sets[i] = '0;
    sets[0].integ[0] = 12'd100; sets[0].integ[1] = 12'd50; sets[0].integ[2] = 12'd600;
    sets[0].integ[4] = 12'd599; sets[0].cp = 10'd10; sets[0].dop = 16'sd11; sets[0].sat_base = 6'd1;
    sets[1].integ[0] = 12'd500; sets[1].integ[1] = 12'd40; sets[1].integ[2] = 12'd599;
    sets[1].integ[4] = 12'd599; sets[1].cp = 10'd20; sets[1].dop = 16'sd22; sets[1].sat_base = 6'd9;
    sets[2].integ[0] = 12'd300; sets[2].integ[1] = 12'd60; sets[2].integ[2] = 12'd600;
    sets[2].integ[4] = 12'd599; sets[2].cp = 10'd30; sets[2].dop = 16'sd33; sets[2].sat_base = 6'd17;
    sets[3].integ[3] = 12'd700; sets[3].integ[6] = 12'd1; sets[3].integ[7] = 12'd1;
    sets[3].cp = 10'd5; sets[3].dop = -16'sd330; sets[3].sat_base = 6'd1;
    sets[4].integ[3] = 12'd700; sets[4].integ[7] = 12'd4095;
    sets[4].cp = 10'd9; sets[4].dop = -16'sd1000; sets[4].sat_base = 6'd9;
    sets[5].integ[1] = 12'd900; sets[5].cp = 10'd77; sets[5].dop = 16'sd5; sets[5].sat_base = 6'd1;

    for (int i = 0; i < 32; i++) exp_tbl[i] = '0;
    exp_tbl[0]  = '{12'd500,  10'd20, 16'sd22,    6'd9,  1'b0};
    exp_tbl[1]  = '{12'd60,   10'd30, 16'sd33,    6'd18, 1'b0};
    exp_tbl[2]  = '{12'd600,  10'd10, 16'sd11,    6'd3,  1'b1};
    exp_tbl[4]  = '{12'd599,  10'd10, 16'sd11,    6'd5,  1'b0};
    exp_tbl[11] = '{12'd700,  10'd5,  -16'sd330,  6'd4,  1'b1};
    exp_tbl[14] = '{12'd1,    10'd5,  -16'sd330,  6'd7,  1'b0};
    exp_tbl[15] = '{12'd4095, 10'd9,  -16'sd1000, 6'd16, 1'b1};
    exp_tbl[17] = '{12'd900,  10'd77, 16'sd5,     6'd2,  1'b1};
    exp_cnt[0] = 20'd3; exp_cnt[1] = 20'd2; exp_cnt[2] = 20'd1; exp_cnt[3] = 20'd0;

    for (int n = 0; n < 8; n++) begin
      sat[n] = '0;
      integ[n] = '0;
    end
    res_if.res_ready = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_valid", 32'(res_if.res_valid), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_count", 32'(corr_count), 32'd0);
    check("rst_done",  32'(report_done), 32'd0);
    check("rst_peak",  32'(res_if.res_peak), 32'd0);
    @(negedge clk) rst = 1'b1;

    // result and search strobes while IDLE are ignored
    apply_set(0, 1'b1);
    check("idle_count", 32'(corr_count), 32'd0);
    check("idle_busy",  32'(busy), 32'd0);
    check("idle_valid", 32'(res_if.res_valid), 32'd0);

    // lane0 100/500/300; ties, the threshold boundary and empty lanes
    start_search();
    check("accum_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 3; k++) apply_set(k, 1'b0);
    search_edge();
    collect(0, 8, -1);

    // lane3 tie at 700 keeps the first result; consumer stalls on lane 4
    start_search();
    apply_set(3, 1'b0);
    apply_set(4, 1'b0);
    search_edge();
    collect(1, 8, 4);

    // reset in the middle of ACCUM
    start_search();
    apply_set(0, 1'b0);
    check("pre_rst_count", 32'(corr_count), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(res_if.res_valid), 32'd0);
    check("arst_busy",  32'(busy), 32'd0);
    check("arst_count", 32'(corr_count), 32'd0);
    check("arst_peak",  32'(res_if.res_peak), 32'd0);
    check("arst_lane",  32'(res_if.res_lane), 32'd0);
    check("arst_cp",    32'(res_if.res_code_phase), 32'd0);
    check("arst_dop",   32'(res_if.res_doppler), 32'd0);
    check("arst_sat",   32'(res_if.res_sat), 32'd0);
    check("arst_det",   32'(res_if.res_detected), 32'd0);
    check("arst_done",  32'(report_done), 32'd0);
    @(negedge clk) rst = 1'b1;
    apply_set(2, 1'b0);
    apply_set(1, 1'b1);
    @(negedge clk);
    check("post_rst_count", 32'(corr_count), 32'd0);
    check("post_rst_busy",  32'(busy), 32'd0);
    check("post_rst_valid", 32'(res_if.res_valid), 32'd0);

    // result edge and search edge on the same cycle
    start_search();
    apply_set(5, 1'b1);
    collect(2, 8, -1);

    // ack_start after three records aborts the report
    start_search();
    for (int k = 0; k < 3; k++) apply_set(k, 1'b0);
    search_edge();
    collect(0, 3, -1);
    d = done_cnt;
    ack_start = 1'b1;
    @(negedge clk);
    ack_start = 1'b0;
    check("abort_valid", 32'(res_if.res_valid), 32'd0);
    check("abort_busy",  32'(busy), 32'd1);
    check("abort_count", 32'(corr_count), 32'd0);
    repeat (2) @(negedge clk);
    check("abort_nodone", 32'(done_cnt - d), 32'd0);
    search_edge();
    collect(3, 8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
